operand_sweep_gen: RTL and testbench

Stimulus-generator stage sitting directly upstream of `top`. Produces the three operand buses `in1`/`in2`/`in3` that `top` consumes, either as an exhaustive nested sweep (innermost `in3`) or as a pseudo-random stream from a 64-bit LFSR. Uses a valid/ready handshake so downstream capture logic can stall it. Reports completion with a one-cycle `done` pulse and an accepted-vector count.

---
 rtl/operand_sweep_gen_pkg.sv | 21 ++
 rtl/operand_sweep_gen_if.sv | 11 +
 rtl/operand_sweep_gen_counter3.sv | 56 +++++
 rtl/operand_sweep_gen.sv | 143 ++++++++++++++
 tb/tb_operand_sweep_gen.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/operand_sweep_gen_pkg.sv
// Shared types and constants for the operand sweep/random stimulus generator.
package sweep_gen_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_RAND  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Feedback taps for x^64+x^63+x^61+x^60+1 (bits 63,62,60,59).
  localparam logic [63:0] LFSR_TAPS    = 64'hD800_0000_0000_0000;
  localparam logic [63:0] DEFAULT_SEED = 64'h1;
  localparam int          PAT_CNT_W    = 32;

  // Fibonacci step: shift up, XOR of tapped bits enters at bit 0.
  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return {s[62:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/operand_sweep_gen_if.sv
// Valid/ready operand bus between the generator and the downstream consumer.
interface operand_sweep_gen_if #(parameter int W = 19);
  logic         valid;
  logic         ready;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic [W-1:0] in3;

  modport master (output valid, output in1, output in2, output in3, input  ready);
  modport slave  (input  valid, input  in1, input  in2, input  in3, output ready);
endinterface

// File: rtl/operand_sweep_gen_counter3.sv
// Three chained inclusive-bound counters; cnt3 is the fastest digit.
// Exposes the post-advance values so the owner can register them directly.
module sweep_counter3 #(
  parameter int LIMIT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               advance_i,
  input  logic [LIMIT_W-1:0] lim1_i,
  input  logic [LIMIT_W-1:0] lim2_i,
  input  logic [LIMIT_W-1:0] lim3_i,
  output logic [LIMIT_W-1:0] nxt1_o,
  output logic [LIMIT_W-1:0] nxt2_o,
  output logic [LIMIT_W-1:0] nxt3_o,
  output logic               last_o
);

  logic [LIMIT_W-1:0] c1_q, c2_q, c3_q;
  logic [LIMIT_W-1:0] c1_d, c2_d, c3_d;
  logic               wrap3, wrap2;

  // Ripple-carry next state: a digit wraps to zero after its bound.
  always_comb begin
    wrap3 = (c3_q == lim3_i);
    wrap2 = wrap3 && (c2_q == lim2_i);
    c3_d  = wrap3 ? '0 : c3_q + LIMIT_W'(1);
    c2_d  = c2_q;
    if (wrap3) c2_d = (c2_q == lim2_i) ? '0 : c2_q + LIMIT_W'(1);
    c1_d  = c1_q;
    if (wrap2) c1_d = (c1_q == lim1_i) ? '0 : c1_q + LIMIT_W'(1);
  end

  // Counter state: cleared at run start, stepped per accepted vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c1_q <= '0;
      c2_q <= '0;
      c3_q <= '0;
    end else if (clr_i) begin
      c1_q <= '0;
      c2_q <= '0;
      c3_q <= '0;
    end else if (advance_i) begin
      c1_q <= c1_d;
      c2_q <= c2_d;
      c3_q <= c3_d;
    end
  end

  assign nxt1_o = c1_d;
  assign nxt2_o = c2_d;
  assign nxt3_o = c3_d;
  assign last_o = wrap2 && (c1_q == lim1_i);

endmodule

// File: rtl/operand_sweep_gen.sv
// Operand stimulus generator: exhaustive nested sweep or LFSR random stream,
// presented over a valid/ready bus with every output driven from a register.
module operand_sweep_gen
  import sweep_gen_pkg::*;
#(
  parameter int          W       = 19,
  parameter int          LIMIT_W = 8,
  parameter logic [63:0] SEED    = DEFAULT_SEED
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [LIMIT_W-1:0]   lim1,
  input  logic [LIMIT_W-1:0]   lim2,
  input  logic [LIMIT_W-1:0]   lim3,
  input  logic [15:0]          num_rand,
  operand_sweep_gen_if.master  bus,
  output logic                 busy,
  output logic                 done,
  output logic [PAT_CNT_W-1:0] pat_cnt
);

  state_e               state_q;
  logic [LIMIT_W-1:0]   lim1_q, lim2_q, lim3_q;
  logic [15:0]          rem_q;
  logic [63:0]          lfsr_q, lfsr_d;
  logic                 valid_q, busy_q, done_q;
  logic [W-1:0]         in1_q, in2_q, in3_q;
  logic [PAT_CNT_W-1:0] pat_q, pat_d;
  logic [LIMIT_W-1:0]   nxt1, nxt2, nxt3;
  logic                 cnt_last, acc, cnt_clr, cnt_adv;

  assign acc     = valid_q & bus.ready;
  assign lfsr_d  = lfsr_step(lfsr_q);
  assign pat_d   = (pat_q == '1) ? pat_q : pat_q + PAT_CNT_W'(1);
  assign cnt_clr = (state_q == S_IDLE) && start && !mode;
  assign cnt_adv = (state_q == S_SWEEP) && acc && !cnt_last;

  sweep_counter3 #(.LIMIT_W(LIMIT_W)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (cnt_clr),
    .advance_i (cnt_adv),
    .lim1_i    (lim1_q),
    .lim2_i    (lim2_q),
    .lim3_i    (lim3_q),
    .nxt1_o    (nxt1),
    .nxt2_o    (nxt2),
    .nxt3_o    (nxt3),
    .last_o    (cnt_last)
  );

  // Control FSM plus registered bus/status outputs; bus only moves on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lim1_q  <= '0;
      lim2_q  <= '0;
      lim3_q  <= '0;
      rem_q   <= '0;
      lfsr_q  <= SEED;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      in1_q   <= '0;
      in2_q   <= '0;
      in3_q   <= '0;
      pat_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          lim1_q <= lim1;
          lim2_q <= lim2;
          lim3_q <= lim3;
          rem_q  <= num_rand;
          lfsr_q <= SEED;
          pat_q  <= '0;
          if (!mode) begin
            state_q <= S_SWEEP;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            in1_q   <= '0;
            in2_q   <= '0;
            in3_q   <= '0;
          end else if (num_rand != 16'd0) begin
            state_q <= S_RAND;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            in1_q   <= SEED[W-1:0];
            in2_q   <= SEED[W+18:19];
            in3_q   <= SEED[W+37:38];
          end else begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_SWEEP: if (acc) begin
          pat_q <= pat_d;
          if (cnt_last) begin
            state_q <= S_DONE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            in1_q <= W'(nxt1);
            in2_q <= W'(nxt2);
            in3_q <= W'(nxt3);
          end
        end
        S_RAND: if (acc) begin
          pat_q  <= pat_d;
          rem_q  <= rem_q - 16'd1;
          lfsr_q <= lfsr_d;
          if (rem_q == 16'd1) begin
            state_q <= S_DONE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            in1_q <= lfsr_d[W-1:0];
            in2_q <= lfsr_d[W+18:19];
            in3_q <= lfsr_d[W+37:38];
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.valid = valid_q;
  assign bus.in1   = in1_q;
  assign bus.in2   = in2_q;
  assign bus.in3   = in3_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pat_cnt   = pat_q;

endmodule

// File: tb/tb_operand_sweep_gen.sv
// Directed bench for operand_sweep_gen: sweep, backpressure, random, reset abort.
module tb_operand_sweep_gen;

  localparam int W = 19;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [7:0]  lim1 = '0, lim2 = '0, lim3 = '0;
  logic [15:0] num_rand = '0;
  logic        busy, done;
  logic [31:0] pat_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  operand_sweep_gen_if #(.W(W)) bus ();

  operand_sweep_gen #(.W(W), .LIMIT_W(8), .SEED(64'h1)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .lim1     (lim1),
    .lim2     (lim2),
    .lim3     (lim3),
    .num_rand (num_rand),
    .bus      (bus.master),
    .busy     (busy),
    .done     (done),
    .pat_cnt  (pat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] vec(input int a, input int b, input int c);
    logic [18:0] x, y, z;
    x = 19'(a); y = 19'(b); z = 19'(c);
    return {7'd0, x, y, z};
  endfunction

  function automatic logic [63:0] bus_vec();
    return {7'd0, bus.in1, bus.in2, bus.in3};
  endfunction

  // Independent LFSR model: new bit0 = s63^s62^s60^s59.
  function automatic logic [63:0] model_step(input logic [63:0] s);
    logic fb;
    fb = s[63] ^ s[62] ^ s[60] ^ s[59];
    return {s[62:0], fb};
  endfunction

  // Called at a negedge; returns at the next negedge with vector 0 on the bus.
  task automatic do_start(input logic m, input int a, input int b, input int c, input int nr);
    start = 1'b1; mode = m;
    lim1 = 8'(a); lim2 = 8'(b); lim3 = 8'(c); num_rand = 16'(nr);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    logic [63:0] s;
    int idx, stalls, guard;
    bus.ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_valid", 64'(bus.valid), 64'd0);
    check_eq("rst_vec", bus_vec(), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_patcnt", 64'(pat_cnt), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Exhaustive sweep 15/15/15
    do_start(1'b0, 15, 15, 15, 0);
    check_eq("sw_busy", 64'(busy), 64'd1);
    check_eq("sw_first", bus_vec(), vec(0, 0, 0));
    for (int i = 0; i < 4096; i++) begin
      check_eq("sw_valid", 64'(bus.valid), 64'd1);
      check_eq("sw_vec", bus_vec(), vec(i >> 8, (i >> 4) & 15, i & 15));
      if (i == 16)   check_eq("sw_vec16", bus_vec(), vec(0, 1, 0));
      if (i == 4095) check_eq("sw_last", bus_vec(), vec(15, 15, 15));
      @(negedge clk);
    end
    check_eq("sw_done", 64'(done), 64'd1);
    check_eq("sw_valid_off", 64'(bus.valid), 64'd0);
    check_eq("sw_busy_off", 64'(busy), 64'd0);
    check_eq("sw_patcnt", 64'(pat_cnt), 64'd4096);
    @(negedge clk);
    check_eq("sw_done_pulse", 64'(done), 64'd0);
    check_eq("sw_patcnt_hold", 64'(pat_cnt), 64'd4096);

    // Backpressure 3/3/3: stall 3 cycles on (0,0,2); stray start mid-run
    do_start(1'b0, 3, 3, 3, 0);
    idx = 0; stalls = 0; guard = 0;
    while (idx < 64 && guard < 200) begin
      check_eq("bp_valid", 64'(bus.valid), 64'd1);
      check_eq("bp_vec", bus_vec(), vec(idx >> 4, (idx >> 2) & 3, idx & 3));
      start = (idx == 10); mode = 1'b1; num_rand = 16'd0;
      if (idx == 2 && stalls < 3) begin
        bus.ready = 1'b0; stalls++;
      end else begin
        bus.ready = 1'b1; idx++;
      end
      guard++;
      @(negedge clk);
    end
    start = 1'b0; mode = 1'b0; bus.ready = 1'b1;
    check_eq("bp_bound", 64'(guard), 64'd67);
    check_eq("bp_done", 64'(done), 64'd1);
    check_eq("bp_patcnt", 64'(pat_cnt), 64'd64);
    @(negedge clk);

    // Minimal sweep 0/0/0
    do_start(1'b0, 0, 0, 0, 0);
    check_eq("min_valid", 64'(bus.valid), 64'd1);
    check_eq("min_vec", bus_vec(), vec(0, 0, 0));
    @(negedge clk);
    check_eq("min_done", 64'(done), 64'd1);
    check_eq("min_valid_off", 64'(bus.valid), 64'd0);
    check_eq("min_patcnt", 64'(pat_cnt), 64'd1);
    @(negedge clk);

    // Random, 5 vectors from SEED=1
    do_start(1'b1, 0, 0, 0, 5);
    check_eq("rnd_first", bus_vec(), vec(1, 0, 0));
    s = 64'h1;
    for (int k = 0; k < 5; k++) begin
      check_eq("rnd_valid", 64'(bus.valid), 64'd1);
      check_eq("rnd_vec", bus_vec(), {7'd0, s[18:0], s[37:19], s[56:38]});
      s = model_step(s);
      @(negedge clk);
    end
    check_eq("rnd_done", 64'(done), 64'd1);
    check_eq("rnd_patcnt", 64'(pat_cnt), 64'd5);
    @(negedge clk);

    // Random with zero count
    do_start(1'b1, 0, 0, 0, 0);
    check_eq("rz_valid", 64'(bus.valid), 64'd0);
    check_eq("rz_done", 64'(done), 64'd1);
    check_eq("rz_patcnt", 64'(pat_cnt), 64'd0);
    @(negedge clk);
    check_eq("rz_done_pulse", 64'(done), 64'd0);
    check_eq("rz_valid2", 64'(bus.valid), 64'd0);

    // Asynchronous reset after 100 accepted vectors
    do_start(1'b0, 15, 15, 15, 0);
    repeat (100) @(negedge clk);
    check_eq("ar_patcnt_pre", 64'(pat_cnt), 64'd100);
    #2 rst = 1'b1;
    #1;
    check_eq("ar_valid", 64'(bus.valid), 64'd0);
    check_eq("ar_vec", bus_vec(), 64'd0);
    check_eq("ar_busy", 64'(busy), 64'd0);
    check_eq("ar_done", 64'(done), 64'd0);
    check_eq("ar_patcnt", 64'(pat_cnt), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("ar_no_done", 64'(done), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    do_start(1'b0, 15, 15, 15, 0);
    check_eq("ar_restart_vec", bus_vec(), vec(0, 0, 0));
    check_eq("ar_restart_cnt", 64'(pat_cnt), 64'd0);
    @(negedge clk);
    check_eq("ar_second_vec", bus_vec(), vec(0, 0, 1));
    check_eq("ar_second_cnt", 64'(pat_cnt), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
